// File: rtl/mesh_drain_arbiter.sv
// Round-robin drain of mesh terminal output FIFOs into a single valid/ready packet stream.
// One packet is popped in IDLE and held in HOLD until the sink accepts it.
module mesh_drain_arbiter #(
  parameter int NTERM     = 16,
  parameter int PAKG_SIZE = 32,
  parameter int IDW       = $clog2(NTERM)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic [NTERM-1:0]           pndng_i,
  input  logic [NTERM*PAKG_SIZE-1:0] data_out_i,
  output logic [NTERM-1:0]           pop_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [PAKG_SIZE-1:0]       out_data_o,
  output logic [IDW-1:0]             out_src_o,
  output logic [15:0]                out_count_o
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant_p0;
  logic           any_p0;
  logic           take_p0;
  logic           accept_p0;
  logic [IDW:0]   idx_w;

  function automatic logic [IDW-1:0] ptr_wrap(input logic [IDW-1:0] src);
    if (src == IDW'(NTERM - 1)) return '0;
    return src + IDW'(1);
  endfunction

  // Stage 0: grant search starting at rr_ptr; highest offset scanned first so the
  // nearest pending terminal overwrites and wins.
  always_comb begin
    grant_p0 = '0;
    any_p0   = 1'b0;
    idx_w    = '0;
    for (int k = NTERM - 1; k >= 0; k--) begin
      idx_w = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (idx_w >= (IDW+1)'(NTERM)) idx_w = idx_w - (IDW+1)'(NTERM);
      if (pndng_i[idx_w[IDW-1:0]]) begin
        grant_p0 = idx_w[IDW-1:0];
        any_p0   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pop_o     = '0;
    take_p0   = 1'b0;
    accept_p0 = 1'b0;
    case (state_q)
      IDLE: begin
        // Reset also masks the pop strobe, since the FIFO would lose a word otherwise.
        if (en_i && any_p0 && !rst_i) begin
          take_p0         = 1'b1;
          pop_o[grant_p0] = 1'b1;
          state_d         = HOLD;
        end
      end
      HOLD: begin
        if (out_ready_i) begin
          accept_p0 = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Stage 1: captured packet, source index, pointer and accept counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr      <= '0;
      out_data_o  <= '0;
      out_src_o   <= '0;
      out_count_o <= '0;
    end else begin
      if (take_p0) begin
        out_data_o <= data_out_i[grant_p0*PAKG_SIZE +: PAKG_SIZE];
        out_src_o  <= grant_p0;
      end
      if (accept_p0) begin
        out_count_o <= out_count_o + 16'd1;
        rr_ptr      <= ptr_wrap(out_src_o);
      end
    end
  end

  assign out_valid_o = (state_q == HOLD);

endmodule

// File: tb/tb_mesh_drain_arbiter.sv
// Bench for mesh_drain_arbiter: vector table, directed corner sequences and a
// randomized run against a queue-free behavioural model.
module tb_mesh_drain_arbiter;
  localparam int NTERM = 16;
  localparam int PW    = 32;

  logic                  clk = 1'b0;
  logic                  rst_i;
  logic                  en_i;
  logic [NTERM-1:0]      pndng_i;
  logic [NTERM*PW-1:0]   data_out_i;
  logic [NTERM-1:0]      pop_o;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [PW-1:0]         out_data_o;
  logic [3:0]            out_src_o;
  logic [15:0]           out_count_o;

  int total = 0;
  int bad   = 0;

  mesh_drain_arbiter #(.NTERM(NTERM), .PAKG_SIZE(PW)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .pndng_i(pndng_i),
    .data_out_i(data_out_i), .pop_o(pop_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_data_o(out_data_o), .out_src_o(out_src_o),
    .out_count_o(out_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [15:0] pnd;
    logic        rdy;
    logic [15:0] exp_pop;
    logic        exp_vld;
    logic [3:0]  exp_src;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic en, input logic [15:0] pnd, input logic rdy);
    en_i = en; pndng_i = pnd; out_ready_i = rdy;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_tagged_data();
    for (int i = 0; i < NTERM; i++) data_out_i[i*PW +: PW] = 32'hCAFE0000 | 32'(i);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    drive(1'b0, 16'h0, 1'b0);
    tick(); tick();
    rst_i = 1'b0;
  endtask

  // First pending index scanning from ptr, modulo NTERM; -1 if none.
  function automatic int rr_pick(input int ptr, input logic [15:0] p);
    for (int k = 0; k < NTERM; k++)
      if (p[(ptr + k) % NTERM]) return (ptr + k) % NTERM;
    return -1;
  endfunction

  function automatic bit onehot0(input logic [15:0] v);
    return (v & (v - 16'd1)) == 16'd0;
  endfunction

  initial begin
    int          srcs[$];
    bit          m_hold;
    int          m_ptr, m_src, g;
    logic [31:0] m_data;
    logic [15:0] m_cnt, exp_pop;
    logic        en_r, rdy_r;
    logic [15:0] pnd_r;

    rst_i = 1'b1;
    data_out_i = '0;
    set_tagged_data();
    drive(1'b1, 16'hFFFF, 1'b1);
    #3;
    chk("rst_pop", 32'(pop_o), 32'h0);
    chk("rst_valid", 32'(out_valid_o), 32'h0);
    chk("rst_data", out_data_o, 32'h0);
    chk("rst_src", 32'(out_src_o), 32'h0);
    chk("rst_count", 32'(out_count_o), 32'h0);
    #5;
    chk("rst_pop_after_edge", 32'(pop_o), 32'h0);
    chk("rst_valid_after_edge", 32'(out_valid_o), 32'h0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    // Vector table: inputs applied for one cycle, pop sampled mid-cycle, the rest after the edge.
    vecs[0]  = '{1'b1, 16'h0004, 1'b1, 16'h0004, 1'b1, 4'd2,  16'd0};
    vecs[1]  = '{1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0, 4'd2,  16'd1};
    vecs[2]  = '{1'b0, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 4'd2,  16'd1};
    vecs[3]  = '{1'b1, 16'h0003, 1'b0, 16'h0001, 1'b1, 4'd0,  16'd1};
    vecs[4]  = '{1'b0, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 4'd0,  16'd1};
    vecs[5]  = '{1'b1, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 4'd0,  16'd2};
    vecs[6]  = '{1'b1, 16'h8000, 1'b1, 16'h8000, 1'b1, 4'd15, 16'd2};
    vecs[7]  = '{1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0, 4'd15, 16'd3};
    vecs[8]  = '{1'b1, 16'h0009, 1'b1, 16'h0001, 1'b1, 4'd0,  16'd3};
    vecs[9]  = '{1'b1, 16'h0009, 1'b1, 16'h0000, 1'b0, 4'd0,  16'd4};
    vecs[10] = '{1'b1, 16'h0009, 1'b1, 16'h0008, 1'b1, 4'd3,  16'd4};
    vecs[11] = '{1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0, 4'd3,  16'd5};
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].en, vecs[i].pnd, vecs[i].rdy);
      #3;
      chk($sformatf("vec%0d_pop", i), 32'(pop_o), 32'(vecs[i].exp_pop));
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid_o), 32'(vecs[i].exp_vld));
      chk($sformatf("vec%0d_src", i), 32'(out_src_o), 32'(vecs[i].exp_src));
      chk($sformatf("vec%0d_data", i), out_data_o, 32'hCAFE0000 | 32'(vecs[i].exp_src));
      chk($sformatf("vec%0d_count", i), 32'(out_count_o), 32'(vecs[i].exp_cnt));
    end

    // Round-robin with everything pending.
    do_reset();
    for (int c = 0; c < 34; c++) begin
      drive(1'b1, 16'hFFFF, 1'b1);
      #3;
      chk("rr_onehot", 32'(onehot0(pop_o)), 32'h1);
      if (out_valid_o) srcs.push_back(int'(out_src_o));
      tick();
    end
    chk("rr_len", 32'(srcs.size()), 32'd17);
    for (int i = 0; i < 17; i++)
      chk($sformatf("rr_src%0d", i), (i < srcs.size()) ? 32'(srcs[i]) : 32'hFFFFFFFF, 32'(i % NTERM));

    // Backpressure on terminal 5.
    do_reset();
    drive(1'b1, 16'h0020, 1'b0);
    #3;
    chk("bp_pop", 32'(pop_o), 32'h0020);
    tick();
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 16'hFFFF, 1'b0);
      #3;
      chk("bp_hold_pop", 32'(pop_o), 32'h0);
      chk("bp_hold_valid", 32'(out_valid_o), 32'h1);
      chk("bp_hold_data", out_data_o, 32'hCAFE0005);
      tick();
    end
    drive(1'b1, 16'h0000, 1'b1);
    tick();
    chk("bp_idle_valid", 32'(out_valid_o), 32'h0);
    chk("bp_count", 32'(out_count_o), 32'h1);

    // Enable gate after the pointer has moved to 4.
    do_reset();
    drive(1'b1, 16'h0008, 1'b1);
    tick(); tick();
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, 16'hFFFF, 1'b1);
      #3;
      chk("en_gate_pop", 32'(pop_o), 32'h0);
      tick();
      chk("en_gate_valid", 32'(out_valid_o), 32'h0);
    end
    drive(1'b1, 16'hFFFF, 1'b1);
    #3;
    chk("en_rise_pop", 32'(pop_o), 32'h0010);
    tick();
    chk("en_rise_src", 32'(out_src_o), 32'd4);

    // Reset while holding terminal 7 (pointer at 7 beforehand).
    do_reset();
    drive(1'b1, 16'h0040, 1'b1); tick();
    drive(1'b1, 16'h0000, 1'b1); tick();
    drive(1'b1, 16'h0080, 1'b0); tick();
    chk("mid_pre_valid", 32'(out_valid_o), 32'h1);
    chk("mid_pre_src", 32'(out_src_o), 32'd7);
    drive(1'b1, 16'hFFFF, 1'b0);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid_o), 32'h0);
    chk("mid_rst_count", 32'(out_count_o), 32'h0);
    chk("mid_rst_src", 32'(out_src_o), 32'h0);
    chk("mid_rst_data", out_data_o, 32'h0);
    chk("mid_rst_pop", 32'(pop_o), 32'h0);
    tick();
    rst_i = 1'b0;
    drive(1'b1, 16'h0081, 1'b1);
    #3;
    chk("mid_after_pop", 32'(pop_o), 32'h0001);
    tick();

    // Randomized run against the behavioural model.
    do_reset();
    m_hold = 1'b0; m_ptr = 0; m_src = 0; m_data = '0; m_cnt = '0;
    for (int c = 0; c < 1500; c++) begin
      en_r  = ($urandom_range(0, 4) != 0);
      rdy_r = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0: pnd_r = 16'h0;
        1: pnd_r = 16'(1) << $urandom_range(0, 15);
        2: pnd_r = 16'($urandom) & 16'($urandom) & 16'($urandom);
        default: pnd_r = 16'($urandom);
      endcase
      for (int i = 0; i < NTERM; i++) data_out_i[i*PW +: PW] = $urandom;
      drive(en_r, pnd_r, rdy_r);
      g = rr_pick(m_ptr, pnd_r);
      exp_pop = (!m_hold && en_r && g >= 0) ? (16'(1) << g) : 16'h0;
      #3;
      chk("rnd_pop", 32'(pop_o), 32'(exp_pop));
      if (m_hold) begin
        if (rdy_r) begin
          m_cnt  = m_cnt + 16'd1;
          m_ptr  = (m_src + 1) % NTERM;
          m_hold = 1'b0;
        end
      end else if (en_r && g >= 0) begin
        m_hold = 1'b1;
        m_src  = g;
        m_data = data_out_i[g*PW +: PW];
      end
      tick();
      chk("rnd_valid", 32'(out_valid_o), 32'(m_hold));
      chk("rnd_data", out_data_o, m_data);
      chk("rnd_src", 32'(out_src_o), 32'(m_src));
      chk("rnd_count", 32'(out_count_o), 32'(m_cnt));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
